// File: rtl/ariane_pkg.sv
// Shared types for the branch history table controller.
// Entry, update and prediction bundles plus the 2-bit counter step.
package ariane_pkg;

    typedef struct packed {
        logic       valid;
        logic [1:0] cnt;
    } bht_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic        taken;
        logic        mispredict;
    } bht_update_t;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    function automatic logic [1:0] sat_cnt_update(
        input logic [1:0] cnt,
        input logic       taken
    );
        logic [1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != 2'b11) res = cnt + 2'd1;
        end else begin
            if (cnt != 2'b00) res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bht_ctrl.sv
// BHT controller: clearing sweep, update read-modify-write stage, lookup.
// Optional perf counters are built when BHT_PERF_CNT_EN is defined.
module bht_ctrl
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 64,
    parameter int unsigned INDEX_LSB  = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_bht_i,
    input  logic        debug_mode_i,
    input  logic [63:0] vpc_i,
    output logic        bht_valid_o,
    output logic        bht_taken_o,
    input  logic        upd_valid_i,
    input  logic [63:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic        upd_mispredict_i,
    output logic        init_busy_o,
    output logic [31:0] perf_upd_cnt_o,
    output logic [31:0] perf_mispredict_cnt_o
);

    localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

    typedef enum logic {INIT, RUN} state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        bht_t             entry;
    } stage_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    stage_t           stage_q, stage_d;
    bht_t             bht_q [NR_ENTRIES];

    bht_update_t      upd;
    bht_prediction_t  pred;
    logic [IDX_W-1:0] upd_idx, lkp_idx, tbl_waddr;
    logic             tbl_we, accept;
    bht_t             tbl_wdata, old_entry, new_entry, lkp_entry;
    logic             unused_bits;

    assign upd = '{
        valid:      upd_valid_i,
        pc:         upd_pc_i,
        taken:      upd_taken_i,
        mispredict: upd_mispredict_i
    };

    assign upd_idx = upd.pc[INDEX_LSB +: IDX_W];
    assign lkp_idx = vpc_i[INDEX_LSB +: IDX_W];
    assign unused_bits = ^{vpc_i, upd.pc, upd.mispredict};

    // Sweep sequencing and selection of the single table write port.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tbl_we    = 1'b0;
        tbl_waddr = stage_q.idx;
        tbl_wdata = stage_q.entry;
        unique case (state_q)
            INIT: begin
                tbl_we    = 1'b1;
                tbl_waddr = idx_q;
                tbl_wdata = '0;
                idx_d     = idx_q + 1'b1;
                if (idx_q == LAST_IDX) state_d = RUN;
            end
            RUN: tbl_we = stage_q.valid && !flush_bht_i;
            default: state_d = INIT;
        endcase
        if (flush_bht_i) begin
            state_d = INIT;
            idx_d   = '0;
        end
    end

    // Accept an update and compute the new entry, forwarding from the stage.
    always_comb begin
        accept = upd.valid && (state_q == RUN)
              && !flush_bht_i && !debug_mode_i;
        old_entry = bht_q[upd_idx];
        if (stage_q.valid && stage_q.idx == upd_idx) begin
            old_entry = stage_q.entry;
        end
        new_entry.valid = 1'b1;
        if (!old_entry.valid) begin
            new_entry.cnt = upd.taken ? 2'b10 : 2'b01;
        end else begin
            new_entry.cnt = sat_cnt_update(old_entry.cnt, upd.taken);
        end
        stage_d = '{valid: accept, idx: upd_idx, entry: new_entry};
    end

    // Control state and update stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            idx_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
        end
    end

    // Table storage; contents are only defined once the sweep has run.
    always_ff @(posedge clk_i) begin
        if (tbl_we) bht_q[tbl_waddr] <= tbl_wdata;
    end

    // Lookup reads the table only; everything reads invalid during a sweep.
    always_comb begin
        lkp_entry  = bht_q[lkp_idx];
        pred.valid = (state_q == RUN) && lkp_entry.valid;
        pred.taken = (state_q == RUN) && lkp_entry.cnt[1];
    end

    assign bht_valid_o = pred.valid;
    assign bht_taken_o = pred.taken;
    assign init_busy_o = (state_q == INIT);

`ifdef BHT_PERF_CNT_EN
    logic [31:0] perf_upd_q, perf_upd_d;
    logic [31:0] perf_mis_q, perf_mis_d;

    // Saturating statistics of accepted updates.
    always_comb begin
        perf_upd_d = perf_upd_q;
        perf_mis_d = perf_mis_q;
        if (accept && perf_upd_q != 32'hFFFF_FFFF) begin
            perf_upd_d = perf_upd_q + 32'd1;
        end
        if (accept && upd.mispredict && perf_mis_q != 32'hFFFF_FFFF) begin
            perf_mis_d = perf_mis_q + 32'd1;
        end
    end

    // Counters survive flushes; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_upd_q <= '0;
            perf_mis_q <= '0;
        end else begin
            perf_upd_q <= perf_upd_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    assign perf_upd_cnt_o        = perf_upd_q;
    assign perf_mispredict_cnt_o = perf_mis_q;
`else
    assign perf_upd_cnt_o        = '0;
    assign perf_mispredict_cnt_o = '0;
`endif

endmodule
